// File: rtl/kmc_exec_ctrl_if.sv
// Bundle of host maintenance inputs and sequencer outputs for the KMC execution controller.
// The master side is the host/line unit; the slave side is kmc_exec_ctrl.
interface kmc_exec_ctrl_if #(
  parameter int unsigned CRAM_AW = 10,
  parameter int unsigned CRAM_DW = 16
);
  logic [7:0]         kmcMAINT;
  logic [CRAM_AW-1:0] kmcSEL4;
  logic [CRAM_DW-1:0] kmcSEL6;
  logic               kmcUSTALL;
  logic               kmcBRANCH;
  logic [CRAM_AW-1:0] kmcBRADDR;
  logic [CRAM_AW-1:0] kmcUPC;
  logic               kmcUEXEC;
  logic               kmcCRAMWE;
  logic [CRAM_AW-1:0] kmcCRAMWA;
  logic [CRAM_DW-1:0] kmcCRAMWD;
  logic               kmcCRAMRD;
  logic               kmcINSEL6;
  logic               kmcHALTED;

  modport master (
    output kmcMAINT, kmcSEL4, kmcSEL6, kmcUSTALL, kmcBRANCH, kmcBRADDR,
    input  kmcUPC, kmcUEXEC, kmcCRAMWE, kmcCRAMWA, kmcCRAMWD, kmcCRAMRD, kmcINSEL6, kmcHALTED
  );

  modport slave (
    input  kmcMAINT, kmcSEL4, kmcSEL6, kmcUSTALL, kmcBRANCH, kmcBRADDR,
    output kmcUPC, kmcUEXEC, kmcCRAMWE, kmcCRAMWA, kmcCRAMWD, kmcCRAMRD, kmcINSEL6, kmcHALTED
  );
endinterface

// File: rtl/kmc_exec_ctrl.sv
// KMC microsequencer control: HALT/RUN/STEP/WRITE/CLEAR FSM driving the micro-PC,
// host CRAM writes and the SEL6 instruction/read paths from the maintenance register.
module kmc_exec_ctrl #(
  parameter int unsigned CRAM_AW = 10,
  parameter int unsigned CRAM_DW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  kmc_exec_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StHalt,
    StRun,
    StStep,
    StWrite,
    StClear
  } state_e;

  state_e             stateQ, stateD;
  logic [CRAM_AW-1:0] upcQ, upcD;
  logic [CRAM_AW-1:0] waQ, waD;
  logic [CRAM_DW-1:0] wdQ, wdD;
  logic               weQ, weD;
  logic               inSel6Q;
  logic               uexec;

  logic runLvl, mclr, cramWr, cramOut, cramIn, stepPulse;
  assign runLvl    = bus.kmcMAINT[7];
  assign mclr      = bus.kmcMAINT[6];
  assign cramWr    = bus.kmcMAINT[5];
  assign cramOut   = bus.kmcMAINT[2];
  assign cramIn    = bus.kmcMAINT[1];
  assign stepPulse = bus.kmcMAINT[0];

  // The cycle RUN drops in StRun is the exit cycle and must not complete an instruction.
  assign uexec = ((stateQ == StRun && runLvl) || stateQ == StStep) &&
                 !bus.kmcUSTALL && !mclr;

  always_comb begin
    stateD = stateQ;
    upcD   = upcQ;
    waD    = waQ;
    wdD    = wdQ;

    if (uexec) begin
      upcD = bus.kmcBRANCH ? bus.kmcBRADDR : upcQ + CRAM_AW'(1);
    end

    if (mclr) begin
      stateD = StClear;
      upcD   = '0;
    end else begin
      unique case (stateQ)
        StHalt: begin
          // A write wins over RUN/STEP; a STEP arriving with it is simply lost.
          if (cramWr) begin
            stateD = StWrite;
            waD    = bus.kmcSEL4;
            wdD    = bus.kmcSEL6;
          end else if (runLvl) begin
            stateD = StRun;
          end else if (stepPulse) begin
            stateD = StStep;
          end
        end
        StRun:   if (!runLvl) stateD = StHalt;
        StStep:  if (uexec) stateD = StHalt;
        StWrite: stateD = StHalt;
        StClear: stateD = runLvl ? StRun : StHalt;
        default: stateD = StHalt;
      endcase
    end

    weD = (stateD == StWrite);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= StHalt;
      upcQ    <= '0;
      waQ     <= '0;
      wdQ     <= '0;
      weQ     <= 1'b0;
      inSel6Q <= 1'b0;
    end else begin
      stateQ  <= stateD;
      upcQ    <= upcD;
      waQ     <= waD;
      wdQ     <= wdD;
      weQ     <= weD;
      inSel6Q <= cramIn;
    end
  end

  assign bus.kmcUPC    = upcQ;
  assign bus.kmcUEXEC  = uexec;
  assign bus.kmcCRAMWE = weQ;
  assign bus.kmcCRAMWA = waQ;
  assign bus.kmcCRAMWD = wdQ;
  assign bus.kmcCRAMRD = cramOut && (stateQ == StHalt);
  assign bus.kmcINSEL6 = inSel6Q;
  assign bus.kmcHALTED = (stateQ == StHalt);

endmodule
